// File: rtl/dyn_mem_pkg.sv
// dyn_mem_pkg: shared TCDM request/response types and arbiter constants
package dyn_mem_pkg;
    localparam int STARVE_CNT_W = 8;
    localparam int TCDM_ADDR_W  = 32;
    localparam int TCDM_DATA_W  = 64;

    typedef logic [STARVE_CNT_W-1:0] starve_cnt_t;

    typedef struct packed {
        logic                     req;
        logic [TCDM_ADDR_W-1:0]   addr;
        logic [TCDM_DATA_W-1:0]   wdata;
        logic                     we;
        logic [TCDM_DATA_W/8-1:0] strb;
    } tcdm_req_t;

    typedef struct packed {
        logic                   rvalid;
        logic                   ecc_err;
        logic [TCDM_DATA_W-1:0] rdata;
    } tcdm_rsp_t;
endpackage

// File: rtl/dyn_mem_rr_starve_sel.sv
// dyn_mem_rr_starve_sel: winner is locked requester, else lowest starving, else round-robin from ptr
module dyn_mem_rr_starve_sel #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] starve,
    input  logic               lock_vld,
    input  logic [IDX_W-1:0]   lock_idx,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner
);
    logic [IDX_W-1:0] st_idx, rr_idx, j;
    logic             st_hit;

    // Downward scans so the last hit is the lowest index / closest to ptr
    always_comb begin
        st_idx = '0;
        st_hit = 1'b0;
        rr_idx = ptr;
        j      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && starve[i]) begin
                st_idx = IDX_W'(i);
                st_hit = 1'b1;
            end
            j = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (req[j]) rr_idx = j;
        end
        winner = (lock_vld && req[lock_idx]) ? lock_idx : st_hit ? st_idx : rr_idx;
    end
endmodule

// File: rtl/dyn_mem_bkgp_arbiter.sv
// dyn_mem_bkgp_arbiter: N-to-1 TCDM bank-group port arbiter with lock, starvation guard and 1-cycle response routing
module dyn_mem_bkgp_arbiter
    import dyn_mem_pkg::*;
#(
    parameter int NUM_REQ               = 4,
    parameter int BANK_GROUP_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH            = 32,
    parameter int STARVE_LIMIT          = 8
) (
    input  logic                                               clk_i,
    input  logic                                               rst_ni,
    input  logic [NUM_REQ-1:0]                                 inp_tcdm_req_i,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]                 inp_tcdm_addr_i,
    input  logic [NUM_REQ-1:0][BANK_GROUP_DATA_WIDTH-1:0]      inp_tcdm_wdata_i,
    input  logic [NUM_REQ-1:0]                                 inp_tcdm_we_i,
    input  logic [NUM_REQ-1:0][BANK_GROUP_DATA_WIDTH/8-1:0]    inp_tcdm_strb_i,
    output logic [NUM_REQ-1:0]                                 inp_tcdm_gnt_o,
    output logic [NUM_REQ-1:0]                                 inp_tcdm_rvalid_o,
    output logic [NUM_REQ-1:0]                                 inp_tcdm_ecc_err_o,
    output logic [NUM_REQ-1:0][BANK_GROUP_DATA_WIDTH-1:0]      inp_tcdm_rdata_o,
    output logic                                               out_tcdm_req_o,
    output logic [ADDR_WIDTH-1:0]                              out_tcdm_addr_o,
    output logic [BANK_GROUP_DATA_WIDTH-1:0]                   out_tcdm_wdata_o,
    output logic                                               out_tcdm_we_o,
    output logic [BANK_GROUP_DATA_WIDTH/8-1:0]                 out_tcdm_strb_o,
    input  logic                                               out_tcdm_gnt_i,
    input  logic                                               out_tcdm_rvalid_i,
    input  logic                                               out_tcdm_ecc_err_i,
    input  logic [BANK_GROUP_DATA_WIDTH-1:0]                   out_tcdm_rdata_i
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]   ptr_q, lock_idx_q, rsp_idx_q, winner;
    logic               lock_vld_q, rsp_vld_q, hs;
    starve_cnt_t        cnt_q [NUM_REQ];
    logic [NUM_REQ-1:0] starve;
    logic               unused_rvalid;

    // Downstream is fixed latency 1, so its rvalid carries no routing information
    assign unused_rvalid = out_tcdm_rvalid_i;

    always_comb begin
        starve = '0;
        for (int i = 0; i < NUM_REQ; i++) starve[i] = cnt_q[i] == starve_cnt_t'(STARVE_LIMIT);
    end

    dyn_mem_rr_starve_sel #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_sel (
        .req      (inp_tcdm_req_i),
        .starve   (starve),
        .lock_vld (lock_vld_q),
        .lock_idx (lock_idx_q),
        .ptr      (ptr_q),
        .winner   (winner)
    );

    assign out_tcdm_req_o   = |inp_tcdm_req_i;
    assign hs               = out_tcdm_req_o & out_tcdm_gnt_i;
    assign out_tcdm_addr_o  = out_tcdm_req_o ? inp_tcdm_addr_i[winner] : '0;
    assign out_tcdm_wdata_o = out_tcdm_req_o ? inp_tcdm_wdata_i[winner] : '0;
    assign out_tcdm_we_o    = out_tcdm_req_o & inp_tcdm_we_i[winner];
    assign out_tcdm_strb_o  = out_tcdm_req_o ? inp_tcdm_strb_i[winner] : '0;
    assign inp_tcdm_gnt_o   = hs ? NUM_REQ'(1) << winner : '0;

    // Gating with rst_ni keeps a response registered just before reset from leaking out
    assign inp_tcdm_rvalid_o  = (rsp_vld_q & rst_ni) ? NUM_REQ'(1) << rsp_idx_q : '0;
    assign inp_tcdm_ecc_err_o = inp_tcdm_rvalid_o & {NUM_REQ{out_tcdm_ecc_err_i}};
    assign inp_tcdm_rdata_o   = {NUM_REQ{out_tcdm_rdata_i}};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            lock_vld_q <= 1'b0;
            lock_idx_q <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_idx_q  <= '0;
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else begin
            lock_vld_q <= out_tcdm_req_o & ~out_tcdm_gnt_i;
            if (out_tcdm_req_o && !out_tcdm_gnt_i) lock_idx_q <= winner;
            rsp_vld_q <= hs;
            if (hs) begin
                rsp_idx_q <= winner;
                ptr_q     <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            end
            for (int i = 0; i < NUM_REQ; i++)
                cnt_q[i] <= (inp_tcdm_req_i[i] && !inp_tcdm_gnt_o[i]) ? (starve[i] ? cnt_q[i] : cnt_q[i] + 1'b1) : '0;
        end
    end
endmodule

// File: tb/tb_dyn_mem_bkgp_arbiter.sv
// tb_dyn_mem_bkgp_arbiter: directed checks of arbitration, lock, starvation, response routing and reset
module tb_dyn_mem_bkgp_arbiter;
    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       req;
    logic [3:0][31:0] addr;
    logic [3:0][63:0] wdata;
    logic [3:0]       we;
    logic [3:0][7:0]  strb;
    logic             gnt_i, rvalid_i, ecc_i;
    logic [63:0]      rdata_i;

    logic [3:0]       a_gnt, a_rvalid, a_ecc, s_gnt, s_rvalid, s_ecc;
    logic [3:0][63:0] a_rdata, s_rdata;
    logic             a_req, a_we, s_req, s_we;
    logic [31:0]      a_addr, s_addr;
    logic [63:0]      a_wdata, s_wdata;
    logic [7:0]       a_strb, s_strb;

    int checks = 0;
    int failures = 0;
    logic [3:0] exp;

    always #5 clk = ~clk;

    dyn_mem_bkgp_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .inp_tcdm_req_i(req), .inp_tcdm_addr_i(addr), .inp_tcdm_wdata_i(wdata),
        .inp_tcdm_we_i(we), .inp_tcdm_strb_i(strb),
        .inp_tcdm_gnt_o(a_gnt), .inp_tcdm_rvalid_o(a_rvalid), .inp_tcdm_ecc_err_o(a_ecc),
        .inp_tcdm_rdata_o(a_rdata),
        .out_tcdm_req_o(a_req), .out_tcdm_addr_o(a_addr), .out_tcdm_wdata_o(a_wdata),
        .out_tcdm_we_o(a_we), .out_tcdm_strb_o(a_strb),
        .out_tcdm_gnt_i(gnt_i), .out_tcdm_rvalid_i(rvalid_i), .out_tcdm_ecc_err_i(ecc_i),
        .out_tcdm_rdata_i(rdata_i)
    );

    dyn_mem_bkgp_arbiter #(.STARVE_LIMIT(2)) dut_s (
        .clk_i(clk), .rst_ni(rst_n),
        .inp_tcdm_req_i(req), .inp_tcdm_addr_i(addr), .inp_tcdm_wdata_i(wdata),
        .inp_tcdm_we_i(we), .inp_tcdm_strb_i(strb),
        .inp_tcdm_gnt_o(s_gnt), .inp_tcdm_rvalid_o(s_rvalid), .inp_tcdm_ecc_err_o(s_ecc),
        .inp_tcdm_rdata_o(s_rdata),
        .out_tcdm_req_o(s_req), .out_tcdm_addr_o(s_addr), .out_tcdm_wdata_o(s_wdata),
        .out_tcdm_we_o(s_we), .out_tcdm_strb_o(s_strb),
        .out_tcdm_gnt_i(gnt_i), .out_tcdm_rvalid_i(rvalid_i), .out_tcdm_ecc_err_i(ecc_i),
        .out_tcdm_rdata_i(rdata_i)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req   = '0;
        gnt_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req   = '0;
        gnt_i = 1'b0;
        ecc_i = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++; if (a_req !== 1'b0) begin failures++; $display("FAIL reset_out_req got=%b exp=0", a_req); end
        checks++; if (a_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", a_addr); end
        checks++; if (a_rvalid !== 4'b0000) begin failures++; $display("FAIL reset_rvalid got=%b exp=0000", a_rvalid); end
        checks++; if (a_ecc !== 4'b0000) begin failures++; $display("FAIL reset_ecc got=%b exp=0000", a_ecc); end
        tick();
        req   = 4'b0100;
        gnt_i = 1'b1;
        @(negedge clk);
        checks++; if (a_gnt !== 4'b0100) begin failures++; $display("FAIL reset_gnt_comb got=%b exp=0100", a_gnt); end
        checks++; if (a_addr !== 32'h102 || a_wdata !== 64'hA2 || a_we !== 1'b1 || a_strb !== 8'h04)
            begin failures++; $display("FAIL reset_payload got=%h/%h/%b/%h exp=102/a2/1/04", a_addr, a_wdata, a_we, a_strb); end
        tick();
        @(negedge clk);
        checks++; if (a_rvalid !== 4'b0000) begin failures++; $display("FAIL reset_no_rsp got=%b exp=0000", a_rvalid); end
        tick();
        rst_n = 1'b1;
        req   = '0;
        gnt_i = 1'b0;
        ecc_i = 1'b0;
        tick();
    endtask

    task automatic test_round_robin;
        do_reset();
        req   = 4'b1111;
        gnt_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp = 4'b0001 << (k % 4);
            checks++; if (a_gnt !== exp) begin failures++; $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, a_gnt, exp); end
            exp = (k == 0) ? 4'b0000 : 4'b0001 << ((k - 1) % 4);
            checks++; if (a_rvalid !== exp) begin failures++; $display("FAIL rr_rvalid k=%0d got=%b exp=%b", k, a_rvalid, exp); end
            tick();
        end
        req   = '0;
        gnt_i = 1'b0;
        @(negedge clk);
        checks++; if (a_rvalid !== 4'b1000) begin failures++; $display("FAIL rr_last_rvalid got=%b exp=1000", a_rvalid); end
        tick();
    endtask

    task automatic test_lock_stall;
        do_reset();
        req   = 4'b0110;
        gnt_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (a_addr !== 32'h101 || a_gnt !== 4'b0000 || a_req !== 1'b1)
                begin failures++; $display("FAIL stall k=%0d got addr=%h gnt=%b req=%b exp addr=101 gnt=0000 req=1", k, a_addr, a_gnt, a_req); end
            tick();
        end
        gnt_i = 1'b1;
        @(negedge clk);
        checks++; if (a_addr !== 32'h101 || a_gnt !== 4'b0010) begin failures++; $display("FAIL stall_release got addr=%h gnt=%b exp addr=101 gnt=0010", a_addr, a_gnt); end
        tick();
        @(negedge clk);
        checks++; if (a_addr !== 32'h102 || a_gnt !== 4'b0100) begin failures++; $display("FAIL stall_next got addr=%h gnt=%b exp addr=102 gnt=0100", a_addr, a_gnt); end
        tick();
        req   = '0;
        gnt_i = 1'b0;
        tick();
    endtask

    task automatic test_starve;
        do_reset();
        req   = 4'b1001;
        gnt_i = 1'b1;
        @(negedge clk);
        checks++; if (s_gnt !== 4'b0001) begin failures++; $display("FAIL starve_c0 got=%b exp=0001", s_gnt); end
        tick();
        req = 4'b1010;
        @(negedge clk);
        checks++; if (s_gnt !== 4'b0010) begin failures++; $display("FAIL starve_c1 got=%b exp=0010", s_gnt); end
        tick();
        req = 4'b1100;
        @(negedge clk);
        checks++; if (s_gnt !== 4'b1000) begin failures++; $display("FAIL starve_win got=%b exp=1000", s_gnt); end
        checks++; if (a_gnt !== 4'b0100) begin failures++; $display("FAIL starve_rr_ref got=%b exp=0100", a_gnt); end
        tick();
        req   = '0;
        gnt_i = 1'b0;
        tick();
    endtask

    task automatic test_read_response;
        do_reset();
        we    = 4'b0000;
        req   = 4'b0100;
        gnt_i = 1'b1;
        @(negedge clk);
        checks++; if (a_gnt !== 4'b0100 || a_we !== 1'b0) begin failures++; $display("FAIL read_gnt got gnt=%b we=%b exp gnt=0100 we=0", a_gnt, a_we); end
        tick();
        req     = '0;
        gnt_i   = 1'b0;
        rdata_i = 64'hDEAD_BEEF;
        ecc_i   = 1'b1;
        @(negedge clk);
        checks++; if (a_rvalid !== 4'b0100) begin failures++; $display("FAIL read_rvalid got=%b exp=0100", a_rvalid); end
        checks++; if (a_ecc !== 4'b0100) begin failures++; $display("FAIL read_ecc got=%b exp=0100", a_ecc); end
        checks++; if (a_rdata[2] !== 64'hDEAD_BEEF) begin failures++; $display("FAIL read_rdata2 got=%h exp=deadbeef", a_rdata[2]); end
        checks++; if (a_rdata[0] !== 64'hDEAD_BEEF) begin failures++; $display("FAIL read_rdata0 got=%h exp=deadbeef", a_rdata[0]); end
        tick();
        @(negedge clk);
        checks++; if (a_rvalid !== 4'b0000 || a_ecc !== 4'b0000) begin failures++; $display("FAIL read_after got rvalid=%b ecc=%b exp 0000/0000", a_rvalid, a_ecc); end
        ecc_i   = 1'b0;
        rdata_i = '0;
        we      = 4'b0101;
        tick();
    endtask

    task automatic test_lock_abandon;
        do_reset();
        req   = 4'b0010;
        gnt_i = 1'b0;
        @(negedge clk);
        checks++; if (a_addr !== 32'h101) begin failures++; $display("FAIL abandon_take got=%h exp=101", a_addr); end
        tick();
        req = 4'b0011;
        @(negedge clk);
        checks++; if (a_addr !== 32'h101) begin failures++; $display("FAIL abandon_hold got=%h exp=101", a_addr); end
        tick();
        req = 4'b1000;
        @(negedge clk);
        checks++; if (a_addr !== 32'h103 || a_gnt !== 4'b0000) begin failures++; $display("FAIL abandon_reselect got addr=%h gnt=%b exp addr=103 gnt=0000", a_addr, a_gnt); end
        tick();
        gnt_i = 1'b1;
        @(negedge clk);
        checks++; if (a_gnt !== 4'b1000) begin failures++; $display("FAIL abandon_grant got=%b exp=1000", a_gnt); end
        tick();
        req   = '0;
        gnt_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_midflight;
        do_reset();
        req   = 4'b0001;
        gnt_i = 1'b1;
        @(negedge clk);
        checks++; if (a_gnt !== 4'b0001) begin failures++; $display("FAIL mid_hs got=%b exp=0001", a_gnt); end
        tick();
        rst_n = 1'b0;
        req   = 4'b1000;
        gnt_i = 1'b0;
        @(negedge clk);
        checks++; if (a_rvalid !== 4'b0000 || s_rvalid !== 4'b0000) begin failures++; $display("FAIL mid_no_pulse got=%b/%b exp=0000/0000", a_rvalid, s_rvalid); end
        tick();
        @(negedge clk);
        checks++; if (a_rvalid !== 4'b0000) begin failures++; $display("FAIL mid_rvalid_held got=%b exp=0000", a_rvalid); end
        tick();
        rst_n = 1'b1;
        req   = 4'b1111;
        gnt_i = 1'b1;
        @(negedge clk);
        checks++; if (a_gnt !== 4'b0001) begin failures++; $display("FAIL mid_ptr_clear got=%b exp=0001", a_gnt); end
        checks++; if (s_gnt !== 4'b0001) begin failures++; $display("FAIL mid_state_clear got=%b exp=0001", s_gnt); end
        checks++; if (a_rvalid !== 4'b0000) begin failures++; $display("FAIL mid_no_rsp got=%b exp=0000", a_rvalid); end
        tick();
        @(negedge clk);
        checks++; if (a_gnt !== 4'b0010 || s_gnt !== 4'b0010) begin failures++; $display("FAIL mid_next got=%b/%b exp=0010/0010", a_gnt, s_gnt); end
        checks++; if (a_rvalid !== 4'b0001) begin failures++; $display("FAIL mid_rvalid got=%b exp=0001", a_rvalid); end
        tick();
        req   = '0;
        gnt_i = 1'b0;
        tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        gnt_i    = 1'b0;
        rvalid_i = 1'b0;
        ecc_i    = 1'b0;
        rdata_i  = '0;
        we       = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            addr[i]  = 32'h100 + 32'(i);
            wdata[i] = 64'hA0 + 64'(i);
            strb[i]  = 8'h01 << i;
        end
        test_reset();
        test_round_robin();
        test_lock_stall();
        test_starve();
        test_read_response();
        test_lock_abandon();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
